cmd_frame_parser: RTL and testbench
===================================

// Module: cmd_frame_parser
// PURPOSE
//  Upstream of the command FSM. Consumes the byte stream from the UART receiver and
//  assembles command frames: opcode, 15-bit address and, for writes, a 32-bit data word.
//  Flags framing errors, then presents one frame per o_done pulse.
//  The command FSM samples o_command/o_address/o_data/o_readwrite/o_error on o_done.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  max clocks between bytes of one frame before abort (>=2)
//  ADDR_W          15         address width; frame carries 16 bits, MSB must be 0
// PORTS
//  clock        in   1   system clock
//  reset        in   1   synchronous, active-high
//  i_byte       in   8   received byte; valid only when i_valid=1
//  i_valid      in   1   one-cycle strobe per received byte
//  o_command    out  8   opcode: 8'h00 write, 8'h01 read
//  o_address    out  15  word address
//  o_data       out  32  write data; 0 for reads
//  o_readwrite  out  1   1=write, 0=read
//  o_done       out  1   one-cycle pulse; frame (or error) outputs valid this cycle
//  o_error      out  2   00 ok, 01 unknown opcode, 10 inter-byte timeout, 11 address MSB set
//  o_busy       out  1   1 while a frame is partially received
// BEHAVIOUR
//  Reset (synchronous): all outputs 0, FSM->S_IDLE, byte counter and timeout counter cleared.
//  Frame format, big-endian: [op][addr_hi][addr_lo] then, for op=00 only, [d3][d2][d1][d0].
//  FSM states:
//  - S_IDLE: on i_valid, latch op.
//    - op in {00,01}: ->S_ADDR_HI.
//    - Otherwise: error 01, ->S_DONE.
//  - S_ADDR_HI: on i_valid, latch addr[14:8]. If byte[7]=1, set error 11 but continue.
//    ->S_ADDR_LO.
//  - S_ADDR_LO: on i_valid, latch addr[7:0].
//    - Read: ->S_DONE.
//    - Write: clear data shift register, byte counter=0, ->S_DATA.
//  - S_DATA: on each i_valid, data<={data[23:0],byte}, counter++. After 4th byte ->S_DONE.
//  - S_DONE: o_done=1 for exactly this cycle; o_error carries the pending code; ->S_IDLE.
//    - A byte arriving with i_valid in S_DONE is NOT lost. It is handled as the opcode of
//      the next frame, i.e. with S_IDLE rules, in the same cycle.
//  Error handling:
//  - Error 11 does not truncate the frame; all bytes are consumed, so the stream stays
//    aligned.
//  - Error 01 ends the frame after one byte; following bytes are parsed as new frames.
//  Outputs:
//  - Registered. o_command/o_address/o_data/o_readwrite are updated only in S_DONE.
//  - They hold until the next S_DONE.
//  - On error frames o_data=0; o_address/o_command hold whatever was latched.
//  Timeout:
//  - Counter runs in every state except S_IDLE and S_DONE; cleared on each accepted byte.
//  - Reaching TIMEOUT_CYCLES-1 forces error 10, ->S_DONE, partial frame discarded.
//  - i_valid in the same cycle as expiry: the byte wins, counter clears, no timeout.
//  Error priority: 10 over 11. 01 cannot coexist with the others.
//  o_busy=1 in S_ADDR_HI, S_ADDR_LO, S_DATA.
//  Reset mid-frame: partial frame dropped, no o_done emitted.
//  Latency: o_done is asserted the cycle after the final byte's i_valid.
// STRUCTURE
//  Package cmd_pkg:
//  - OP_WRITE=8'h00, OP_READ=8'h01
//  - ERR_NONE/ERR_OPCODE/ERR_TIMEOUT/ERR_ADDR (2'b00..2'b11)
//  - State encodings; WRITE_DATA_BYTES=4
//  Sub-module byte_timeout_timer:
//  - Ports: clock, reset, clear, run, expired.
//  - Width $clog2(TIMEOUT_CYCLES).
// TESTING (bench sets TIMEOUT_CYCLES=64)
//  1 Bytes 00,12,34,DE,AD,BE,EF, 1 byte/10clk -> one o_done; cmd=00, addr=15'h1234,
//    data=DEADBEEF, rw=1, err=00.
//  2 Bytes 01,00,07 -> o_done the cycle after 3rd byte; cmd=01, addr=7, data=0, rw=0, err=00.
//  3 Byte 5A, then 01,00,03 -> first o_done err=01; second o_done err=00, addr=3.
//  4 Bytes 01,80,05 -> o_done err=11 after 3rd byte; next frame 01,00,05 parses clean.
//  5 Bytes 00,00,10,AA then 64 idle clks -> o_done err=10, o_busy falls.
//    - Repeat with the byte landing on the expiry cycle -> no timeout.
//  6 Reset pulse after 00,00 -> no o_done, all outputs 0; following read frame parses correctly.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared opcodes, error codes and parser state encoding for the command frame parser.
package cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h00;
    localparam logic [7:0] OP_READ  = 8'h01;

    localparam int unsigned WRITE_DATA_BYTES = 4;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_OPCODE  = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_ADDR    = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_DONE
    } state_e;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts idle cycles while a frame is open, flags expiry at the limit.
module byte_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || clear || !run) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = run && (count_q == LAST);

endmodule

// File: rtl/cmd_frame_parser.sv
// Assembles opcode/address/data command frames from a UART byte stream and reports
// each completed (or failed) frame with a one-cycle done pulse.
module cmd_frame_parser
    import cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned ADDR_W         = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        i_byte,
    input  logic              i_valid,
    output logic [7:0]        o_command,
    output logic [ADDR_W-1:0] o_address,
    output logic [31:0]       o_data,
    output logic              o_readwrite,
    output logic              o_done,
    output logic [1:0]        o_error,
    output logic              o_busy
);

    state_e            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        cnt_q, cnt_d;
    err_e              err_q, err_d;
    logic              expired;

    assign o_busy = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) || (state_q == S_DATA);
    assign o_done = (state_q == S_DONE);

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (i_valid),
        .run    (o_busy),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            // The done cycle accepts the next opcode exactly like idle, so no byte is lost.
            S_IDLE, S_DONE: begin
                if (i_valid) begin
                    op_d   = i_byte;
                    data_d = '0;
                    err_d  = ERR_NONE;
                    if (i_byte == OP_WRITE || i_byte == OP_READ) begin
                        state_d = S_ADDR_HI;
                    end else begin
                        err_d   = ERR_OPCODE;
                        state_d = S_DONE;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR_HI: begin
                if (i_valid) begin
                    addr_d[ADDR_W-1:8] = i_byte[ADDR_W-9:0];
                    if (|i_byte[7:ADDR_W-8]) begin
                        err_d = ERR_ADDR;
                    end
                    state_d = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (i_valid) begin
                    addr_d[7:0] = i_byte;
                    if (op_q == OP_READ) begin
                        state_d = S_DONE;
                    end else begin
                        data_d  = '0;
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (i_valid) begin
                    data_d = {data_q[23:0], i_byte};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'(WRITE_DATA_BYTES - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A byte on the expiry cycle wins; timeout also overrides a pending address error.
        if (expired && !i_valid) begin
            err_d   = ERR_TIMEOUT;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            err_q       <= ERR_NONE;
            o_command   <= '0;
            o_address   <= '0;
            o_data      <= '0;
            o_readwrite <= 1'b0;
            o_error     <= 2'b00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            // Load the frame outputs on entry to S_DONE so they are valid with o_done.
            if (state_d == S_DONE) begin
                o_command   <= op_d;
                o_address   <= addr_d;
                o_data      <= (err_d == ERR_NONE) ? data_d : 32'h0;
                o_readwrite <= (op_d == OP_WRITE);
                o_error     <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Randomized and directed bench for cmd_frame_parser against a byte-stream frame model.
module tb_cmd_frame_parser;

    localparam int T = 64;

    typedef struct {
        logic [7:0] b;
        int         gap;
    } item_t;

    typedef struct {
        int         t;
        logic [7:0] b;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  i_byte = 8'h00;
    logic        i_valid = 1'b0;
    logic [7:0]  o_command;
    logic [14:0] o_address;
    logic [31:0] o_data;
    logic        o_readwrite;
    logic        o_done;
    logic [1:0]  o_error;
    logic        o_busy;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [14:0] m_addr = '0;
    item_t       stim[$];
    ev_t         ev[$];
    logic [89:0] got[$];
    logic [89:0] exp_q[$];

    cmd_frame_parser #(
        .TIMEOUT_CYCLES(T),
        .ADDR_W        (15)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .i_byte     (i_byte),
        .i_valid    (i_valid),
        .o_command  (o_command),
        .o_address  (o_address),
        .o_data     (o_data),
        .o_readwrite(o_readwrite),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_busy     (o_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record {cycle, cmd, addr, data, rw, err} for every done pulse.
    always @(negedge clock) begin
        if (o_done === 1'b1) got.push_back({32'(cyc), o_command, o_address, o_data, o_readwrite,
                                            o_error});
    end

    task automatic add(input logic [7:0] b, input int gap);
        stim.push_back('{b: b, gap: gap});
    endtask

    function automatic int rgap();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 14) return 1 + r % 3;
        if (r < 16) return T;
        if (r < 17) return T + 1;
        return int'($urandom_range(1, 12));
    endfunction

    // Drive the stim queue (gap = cycles since previous strobe), noise on i_byte when idle.
    task automatic drive();
        ev.delete();
        got.delete();
        foreach (stim[i]) begin
            for (int k = 0; k < stim[i].gap; k++) begin
                @(negedge clock);
                if (k == stim[i].gap - 1) begin
                    i_valid = 1'b1;
                    i_byte  = stim[i].b;
                    ev.push_back('{t: cyc, b: stim[i].b});
                end else begin
                    i_valid = 1'b0;
                    i_byte  = 8'($urandom);
                end
            end
        end
        @(negedge clock);
        i_valid = 1'b0;
        repeat (T + 8) @(negedge clock);
        stim.delete();
    endtask

    // Frame model: walks the timestamped byte list and applies the framing rules directly.
    task automatic model();
        int         i;
        int         t;
        int         need;
        logic [7:0] op;
        logic [7:0] b;
        logic [31:0] data;
        logic       aerr;
        logic       to;
        exp_q.delete();
        i = 0;
        while (i < ev.size()) begin
            op = ev[i].b;
            t  = ev[i].t;
            i++;
            if (op != 8'h00 && op != 8'h01) begin
                exp_q.push_back({32'(t + 1), op, m_addr, 32'h0, 1'b0, 2'b01});
                continue;
            end
            need = (op == 8'h00) ? 6 : 2;
            aerr = 1'b0;
            data = '0;
            to   = 1'b0;
            for (int k = 1; k <= need; k++) begin
                if (i >= ev.size() || ev[i].t - t > T) begin
                    to = 1'b1;
                    break;
                end
                b = ev[i].b;
                t = ev[i].t;
                i++;
                if (k == 1) begin
                    m_addr[14:8] = b[6:0];
                    aerr = b[7];
                end else if (k == 2) begin
                    m_addr[7:0] = b;
                end else begin
                    data = {data[23:0], b};
                end
            end
            if (to) exp_q.push_back({32'(t + T + 1), op, m_addr, 32'h0, op == 8'h00, 2'b10});
            else    exp_q.push_back({32'(t + 1), op, m_addr, aerr ? 32'h0 : data, op == 8'h00,
                                     aerr ? 2'b11 : 2'b00});
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        i_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        m_addr = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_command, o_address, o_data, o_readwrite, o_done, o_error, o_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {o_command, o_address, o_data, o_readwrite, o_done, o_error, o_busy});
        end
    endtask

    task automatic test_write();
        add(8'h00, 1); add(8'h12, 10); add(8'h34, 10); add(8'hDE, 10);
        add(8'hAD, 10); add(8'hBE, 10); add(8'hEF, 10);
        drive();
        model();
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL write_count: got %0d frames required %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL write_frame%0d: got %h required %h", i, got[i], exp_q[i]);
            end
        end
        if (got.size() > 0) begin
            checks++;
            if (got[0][57:0] !== {8'h00, 15'h1234, 32'hDEADBEEF, 1'b1, 2'b00}) begin
                errors++;
                $display("FAIL write_const: got %h required %h", got[0][57:0],
                         {8'h00, 15'h1234, 32'hDEADBEEF, 1'b1, 2'b00});
            end
        end
    endtask

    task automatic test_read();
        add(8'h01, 1); add(8'h00, 2); add(8'h07, 3);
        drive();
        model();
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL read_count: got %0d frames required %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL read_frame%0d: got %h required %h", i, got[i], exp_q[i]);
            end
        end
        if (got.size() > 0) begin
            checks++;
            if (got[0][89:0] !== {32'(ev[2].t + 1), 8'h01, 15'h0007, 32'h0, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL read_const: got %h required %h", got[0],
                         {32'(ev[2].t + 1), 8'h01, 15'h0007, 32'h0, 1'b0, 2'b00});
            end
        end
    endtask

    task automatic test_errors();
        // Bad opcode, next frame's opcode lands in the done cycle; then address MSB error.
        add(8'h5A, 5); add(8'h01, 1); add(8'h00, 1); add(8'h03, 1);
        add(8'h01, 4); add(8'h80, 1); add(8'h05, 1);
        add(8'h01, 3); add(8'h00, 1); add(8'h05, 1);
        drive();
        model();
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL err_count: got %0d frames required %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL err_frame%0d: got %h required %h", i, got[i], exp_q[i]);
            end
        end
        if (got.size() == 4) begin
            checks++;
            if ({got[0][1:0], got[1][1:0], got[2][1:0], got[3][1:0]} !== 8'b01_00_11_00) begin
                errors++;
                $display("FAIL err_codes: got %b required 01001100",
                         {got[0][1:0], got[1][1:0], got[2][1:0], got[3][1:0]});
            end
        end
    endtask

    task automatic test_timeout();
        add(8'h00, 1); add(8'h00, 1); add(8'h10, 1); add(8'hAA, 1);
        drive();
        model();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy: got %b required 0", o_busy);
        end
        checks++;
        if (got.size() != 1 || got[0][1:0] !== 2'b10 || got[0][89:58] !== 32'(ev[3].t + T + 1))
        begin
            errors++;
            $display("FAIL timeout_frame: got %0d frames first %h required err 10 at cycle %0d",
                     got.size(), got.size() > 0 ? got[0] : 90'h0, ev[3].t + T + 1);
        end
        // Byte on the expiry cycle is kept; a byte one cycle later is not.
        add(8'h00, 1); add(8'h00, 1); add(8'h10, 1); add(8'hAA, 1);
        add(8'hBB, T); add(8'hCC, 1); add(8'hDD, 1);
        add(8'h00, 3); add(8'h00, 1); add(8'h10, T + 1);
        drive();
        model();
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL expiry_count: got %0d frames required %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL expiry_frame%0d: got %h required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        got.delete();
        @(negedge clock);
        i_valid = 1'b1;
        i_byte  = 8'h00;
        @(negedge clock);
        i_byte  = 8'h00;
        @(negedge clock);
        i_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy: got %b required 1", o_busy);
        end
        do_reset();
        checks++;
        if ({o_command, o_address, o_data, o_readwrite, o_done, o_error, o_busy} !== '0
            || got.size() != 0) begin
            errors++;
            $display("FAIL midreset_state: got outputs %h frames %0d required 0 and 0",
                     {o_command, o_address, o_data, o_readwrite, o_done, o_error, o_busy},
                     got.size());
        end
        add(8'h01, 2); add(8'h00, 1); add(8'h2A, 1);
        drive();
        model();
        checks++;
        if (got.size() != 1 || got[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL midreset_read: got %0d frames first %h required %h", got.size(),
                     got.size() > 0 ? got[0] : 90'h0, exp_q[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] op;
        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < 10; f++) begin
                case ($urandom_range(0, 3))
                    0:       op = 8'h00;
                    3:       op = 8'($urandom);
                    default: op = 8'h01;
                endcase
                add(op, rgap());
                add(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 127)),
                    rgap());
                add(8'($urandom), rgap());
                if (op == 8'h00) for (int k = 0; k < 4; k++) add(8'($urandom), rgap());
            end
            drive();
            model();
            checks++;
            if (got.size() != exp_q.size()) begin
                errors++;
                $display("FAIL random%0d_count: got %0d frames required %0d", r, got.size(),
                         exp_q.size());
            end
            foreach (exp_q[i]) if (i < got.size()) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random%0d_frame%0d: got %h required %h", r, i, got[i],
                             exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
